fiat_25519_carry_mul_mul_arb: RTL and testbench
===============================================

# fiat_25519_carry_mul_mul_arb

Round-robin arbiter and sequencer that shares one combinational signed multiplier (32-bit signed × 7-bit signed → 32-bit truncated product) among NUM_REQ requesters in the fiat_25519 carry_mul datapath. Requesters present operand pairs over valid/ready handshakes. The block registers the granted operands, drives the external multiplier, and captures the product into a response register. Results return in acceptance order, tagged with the requester index, so small-constant scaling multiplies (e.g. ×19, ×38) share a single multiplier instance.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- din0_WIDTH, 32: signed operand A width.
- din1_WIDTH, 7: signed operand B width.
- dout_WIDTH, 32: product width; low dout_WIDTH bits of the full signed product.
- ID_WIDTH, 2: width of the requester tag; must be ≥ clog2(NUM_REQ).

Ports (one clock; reset is synchronous and active-high):
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_din0  in  NUM_REQ*din0_WIDTH  operand A, requester i at slice [i*din0_WIDTH +: din0_WIDTH].
- req_din1  in  NUM_REQ*din1_WIDTH  operand B, same slicing.
- mul_din0  out  din0_WIDTH  to external multiplier din0 (from op register).
- mul_din1  out  din1_WIDTH  to external multiplier din1.
- mul_dout  in  dout_WIDTH  combinational product from external multiplier.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer accept.
- rsp_dout  out  dout_WIDTH  product.
- rsp_id  out  ID_WIDTH  index of the requester that issued it.
- busy  out  1  op_valid | rsp_valid.

## Operation
- Two-stage pipeline:
  - op stage: op_valid, op_a, op_b, op_id.
  - rsp stage: rsp_valid, rsp_dout, rsp_id.
- mul_din0/mul_din1 = op_a/op_b at all times. The multiplier is purely combinational (zero stages).
- rsp_advance = op_valid & (~rsp_valid | rsp_ready). On rsp_advance, the rsp stage loads mul_dout and op_id and sets rsp_valid.
- If rsp_ready & rsp_valid & ~rsp_advance, rsp_valid clears.
- can_accept = ~op_valid | rsp_advance.
- Arbitration:
  - Round-robin pointer rr_ptr.
  - grant = first index i scanning rr_ptr, rr_ptr+1, … (mod NUM_REQ) with req_valid[i]=1.
  - req_ready = onehot(grant) & {NUM_REQ{can_accept & any_valid}}.
- On accept (req_valid[g] & req_ready[g]):
  - op stage loads requester g's slices; op_id = g.
  - rr_ptr = (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- If there is no accept but rsp_advance occurs, op_valid clears.
- rr_ptr does not change without an accept.
- Requester contract: hold req_valid and operands stable until ready. req_valid must not depend on req_ready. The block never drops an accepted operation.
- Arithmetic: rsp_dout = low dout_WIDTH bits of $signed(A)·$signed(B). No saturation and no overflow flag.
- Ordering: responses appear strictly in acceptance order. There are no gaps or duplicates.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_dout=0, rsp_id=0, busy=0.
  - op_valid=0, op_a=0, op_b=0, op_id=0, hence mul_din0=mul_din1=0.
  - rr_ptr=0.
- Reset mid-operation discards both stages; in-flight results are lost. The cycle after ap_rst deasserts behaves as a fresh reset state.
- Latency: an accept at edge N yields rsp_valid=1 after edge N+1, a 2-cycle accept-to-response latency.
- Throughput: 1 op/cycle while rsp_ready=1.
- Backpressure:
  - With rsp_ready=0, both stages fill and req_ready goes 0.
  - rsp_dout/rsp_id hold stable while rsp_valid & ~rsp_ready.
- Simultaneous events:
  - Accept and rsp_advance in the same cycle: the op stage reloads, with no bubble.
  - rsp drain and op advance in the same cycle: rsp reloads, with no bubble.
- All req_valid=0: req_ready=0 and rr_ptr holds.

## Test plan
- Reset check: assert ap_rst for 2 cycles with random inputs -> all outputs 0 during and after reset; first grant with all requesters valid goes to requester 0.
- Single op: requester 2 sends A=0x7FFFFFFF, B=63 (rsp_ready=1) -> rsp_valid 2 cycles after accept, rsp_dout=0x7FFFFFC1, rsp_id=2. Then A=0xFFFFFFFF (−1), B=0x40 (−64) -> rsp_dout=0x00000040.
- Fairness: all 4 requesters continuously valid, rsp_ready=1 -> grant order 0,1,2,3,0,1,… with 1 accept/cycle; every response is correct A·B and in order.
- Backpressure: 4 requesters valid, rsp_ready=0 for 5 cycles -> exactly 2 accepts, then req_ready=0. rsp_dout is stable. After rsp_ready=1, responses drain in order with no loss or duplication.
- Wrap/skip: only requesters 1 and 3 valid, rr_ptr at 2 -> grant 3, then 1, then 3. rr_ptr wraps 3→0 correctly.
- Mid-operation reset: pulse ap_rst with both stages full -> rsp_valid=0 next cycle. No stale result appears later, and rr_ptr restarts at 0.

Source files
------------

// File: rtl/fiat_25519_carry_mul_mul_arb.sv
// Round-robin arbiter that time-shares one external combinational signed multiplier
// among NUM_REQ requesters; results return in acceptance order, tagged with the requester index.
module fiat_25519_carry_mul_mul_arb #(
  parameter int NUM_REQ    = 4,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*din0_WIDTH-1:0]  req_din0,
  input  logic [NUM_REQ*din1_WIDTH-1:0]  req_din1,
  output logic [din0_WIDTH-1:0]          mul_din0,
  output logic [din1_WIDTH-1:0]          mul_din1,
  input  logic [dout_WIDTH-1:0]          mul_dout,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [dout_WIDTH-1:0]          rsp_dout,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic                           busy
);

  logic                  op_valid;
  logic [din0_WIDTH-1:0] op_a;
  logic [din1_WIDTH-1:0] op_b;
  logic [ID_WIDTH-1:0]   op_id;
  logic [ID_WIDTH-1:0]   rr_ptr;

  logic                  rsp_advance;
  logic                  can_accept;
  logic                  any_valid;
  logic                  accept;
  logic [NUM_REQ-1:0]    below_ptr;
  logic [NUM_REQ-1:0]    upper_req;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   grant_upper;
  logic [ID_WIDTH-1:0]   grant_any;
  logic [din0_WIDTH-1:0] grant_a;
  logic [din1_WIDTH-1:0] grant_b;

  assign mul_din0 = op_a;
  assign mul_din1 = op_b;
  assign busy     = op_valid | rsp_valid;

  assign rsp_advance = op_valid & (~rsp_valid | rsp_ready);
  // req_ready is held low while reset is asserted, whatever the requesters drive.
  assign can_accept  = (~op_valid | rsp_advance) & ~ap_rst;
  assign any_valid   = |req_valid;
  assign accept      = can_accept & any_valid;

  // Requesters at or above rr_ptr win first; otherwise wrap to the lowest valid index.
  assign below_ptr = (NUM_REQ'(1) << rr_ptr) - NUM_REQ'(1);
  assign upper_req = req_valid & ~below_ptr;

  always_comb begin
    grant_upper = '0;
    grant_any   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (upper_req[i]) grant_upper = ID_WIDTH'(i);
      if (req_valid[i]) grant_any   = ID_WIDTH'(i);
    end
    grant = (|upper_req) ? grant_upper : grant_any;
  end

  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_WIDTH'(i)) begin
        grant_a = req_din0[i*din0_WIDTH +: din0_WIDTH];
        grant_b = req_din1[i*din1_WIDTH +: din1_WIDTH];
      end
    end
  end

  assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_dout  <= '0;
      rsp_id    <= '0;
    end else begin
      if (accept) begin
        op_valid <= 1'b1;
        op_a     <= grant_a;
        op_b     <= grant_b;
        op_id    <= grant;
        rr_ptr   <= (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end else if (rsp_advance) begin
        op_valid <= 1'b0;
      end

      if (rsp_advance) begin
        rsp_valid <= 1'b1;
        rsp_dout  <= mul_dout;
        rsp_id    <= op_id;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fiat_25519_carry_mul_mul_arb.sv
// Scoreboard bench: accepts push hand-computed products, an independent monitor pops and compares.
module tb_fiat_25519_carry_mul_mul_arb;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [127:0]  req_din0;
  logic [27:0]   req_din1;
  logic [31:0]   mul_din0;
  logic [6:0]    mul_din1;
  logic [31:0]   mul_dout;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_dout;
  logic [1:0]    rsp_id;
  logic          busy;

  fiat_25519_carry_mul_mul_arb dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_din0 (req_din0),
    .req_din1 (req_din1),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dout (rsp_dout),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  // The shared external multiplier: low 32 bits of the signed product.
  assign mul_dout = 32'($signed(mul_din0) * $signed(mul_din1));

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0] p;
    int          id;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          log_id[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          lat_mode = 1'b0;
  bit          held     = 1'b0;
  logic [31:0] held_dout;
  logic [1:0]  held_id;

  logic [31:0] tbl_a[12];
  logic [6:0]  tbl_b[12];
  logic [31:0] tbl_p[12];
  int          list[4][8];
  int          cnt[4];
  int          pos[4];

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic init_tbl();
    tbl_a[0]  = 32'h7FFFFFFF; tbl_b[0]  = 7'h3F; tbl_p[0]  = 32'h7FFFFFC1;
    tbl_a[1]  = 32'hFFFFFFFF; tbl_b[1]  = 7'h40; tbl_p[1]  = 32'h00000040;
    tbl_a[2]  = 32'h00000013; tbl_b[2]  = 7'h13; tbl_p[2]  = 32'h00000169;
    tbl_a[3]  = 32'h00000100; tbl_b[3]  = 7'h26; tbl_p[3]  = 32'h00002600;
    tbl_a[4]  = 32'h12345678; tbl_b[4]  = 7'h01; tbl_p[4]  = 32'h12345678;
    tbl_a[5]  = 32'h00000003; tbl_b[5]  = 7'h7F; tbl_p[5]  = 32'hFFFFFFFD;
    tbl_a[6]  = 32'h80000000; tbl_b[6]  = 7'h02; tbl_p[6]  = 32'h00000000;
    tbl_a[7]  = 32'h0000000A; tbl_b[7]  = 7'h7D; tbl_p[7]  = 32'hFFFFFFE2;
    tbl_a[8]  = 32'h00001000; tbl_b[8]  = 7'h10; tbl_p[8]  = 32'h00010000;
    tbl_a[9]  = 32'hFFFFFFFE; tbl_b[9]  = 7'h3F; tbl_p[9]  = 32'hFFFFFF82;
    tbl_a[10] = 32'h40000000; tbl_b[10] = 7'h03; tbl_p[10] = 32'hC0000000;
    tbl_a[11] = 32'h0000FFFF; tbl_b[11] = 7'h13; tbl_p[11] = 32'h0012FFED;
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      pos[i] = 0;
    end
    log_id.delete();
  endtask

  task automatic add(input int r, input int v);
    list[r][cnt[r]] = v;
    cnt[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (pos[i] < cnt[i]) begin
        req_valid[i]         = 1'b1;
        req_din0[i*32 +: 32] = tbl_a[list[i][pos[i]]];
        req_din1[i*7 +: 7]   = tbl_b[list[i][pos[i]]];
      end else begin
        req_valid[i]         = 1'b0;
        req_din0[i*32 +: 32] = 32'h0;
        req_din1[i*7 +: 7]   = 7'h0;
      end
    end
  endtask

  // One clock: record accepts seen before the edge, then advance requesters after it.
  task automatic tick();
    logic [3:0] acc;
    exp_t       ne;
    acc = 4'b0;
    @(negedge ap_clk);
    if (!ap_rst) begin
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc[i]     = 1'b1;
          ne.p       = tbl_p[list[i][pos[i]]];
          ne.id      = i;
          ne.acc_cyc = cyc;
          ne.lat     = lat_mode;
          sb.push_back(ne);
          log_id.push_back(i);
        end
      end
    end
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) pos[i]++;
    drive();
  endtask

  task automatic run_until(input int n, input int budget);
    int t;
    t = 0;
    while (log_id.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk("accept_count", 64'(log_id.size()), 64'(n));
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < budget) begin
      tick();
      t++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_dout"},  64'(rsp_dout),  64'd0);
    chk({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_mul_din0"},  64'(mul_din0),  64'd0);
    chk({tag, "_mul_din1"},  64'(mul_din1),  64'd0);
  endtask

  // Response monitor, independent of the stimulus thread.
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      held = 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got dout=%h id=%0d expected no response", rsp_dout, rsp_id);
        end else begin
          e = sb.pop_front();
          chk("rsp_dout", 64'(rsp_dout), 64'(e.p));
          chk("rsp_id",   64'(rsp_id),   64'(e.id));
          if (e.lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
        end
      end
      if (rsp_valid && !rsp_ready) begin
        if (held) begin
          chk("hold_dout", 64'(rsp_dout), 64'(held_dout));
          chk("hold_id",   64'(rsp_id),   64'(held_id));
        end
        held      = 1'b1;
        held_dout = rsp_dout;
        held_id   = rsp_id;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    init_tbl();
    clr();
    ap_rst    = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b0;
    req_din0  = '0;
    req_din1  = '0;

    // Reset with random inputs
    repeat (2) begin
      @(posedge ap_clk);
      #1;
      req_valid = 4'($urandom);
      req_din0  = {$urandom, $urandom, $urandom, $urandom};
      req_din1  = 28'($urandom);
      rsp_ready = 1'($urandom);
      @(negedge ap_clk);
      chk_zero("in_reset");
    end
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b0;
    rsp_ready = 1'b1;
    drive();
    @(negedge ap_clk);
    chk_zero("post_reset");
    @(posedge ap_clk);
    #1;

    // Fairness: all four continuously valid
    lat_mode = 1'b1;
    clr();
    add(0, 2);  add(0, 3);  add(0, 4);
    add(1, 5);  add(1, 6);  add(1, 7);
    add(2, 8);  add(2, 9);  add(2, 10);
    add(3, 11); add(3, 0);  add(3, 1);
    drive();
    run_until(12, 30);
    for (int k = 0; k < 12; k++) chk("rr_order", 64'(log_id[k]), 64'(k % 4));
    drain(20);

    // Single requester 2, including the signed extremes
    clr();
    add(2, 0); add(2, 1);
    drive();
    run_until(2, 10);
    chk("single_id0", 64'(log_id[0]), 64'd2);
    drain(20);

    // Backpressure: consumer stalled for 5 cycles
    lat_mode  = 1'b0;
    rsp_ready = 1'b0;
    clr();
    add(0, 2); add(1, 3); add(2, 4); add(3, 5);
    drive();
    repeat (5) tick();
    chk("bp_accepts", 64'(log_id.size()), 64'd2);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    chk("bp_first", 64'(log_id[0]), 64'd3);
    chk("bp_second", 64'(log_id[1]), 64'd0);
    rsp_ready = 1'b1;
    drain(30);
    chk("bp_total", 64'(log_id.size()), 64'd4);
    chk("bp_third", 64'(log_id[2]), 64'd1);
    chk("bp_fourth", 64'(log_id[3]), 64'd2);

    // Move pointer to 2, then only requesters 1 and 3 valid
    lat_mode = 1'b1;
    clr();
    add(1, 6);
    drive();
    run_until(1, 10);
    drain(20);
    clr();
    add(1, 7); add(1, 8);
    add(3, 9); add(3, 10);
    drive();
    run_until(4, 20);
    chk("skip_0", 64'(log_id[0]), 64'd3);
    chk("skip_1", 64'(log_id[1]), 64'd1);
    chk("skip_2", 64'(log_id[2]), 64'd3);
    chk("skip_3", 64'(log_id[3]), 64'd1);
    drain(20);

    // Reset with both stages full
    lat_mode  = 1'b0;
    rsp_ready = 1'b0;
    clr();
    add(0, 10); add(1, 11);
    drive();
    run_until(2, 10);
    tick();
    chk("full_busy", 64'(busy), 64'd1);
    ap_rst = 1'b1;
    sb.delete();
    clr();
    drive();
    tick();
    ap_rst    = 1'b0;
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge ap_clk);
    #1;
    repeat (5) tick();
    lat_mode = 1'b1;
    clr();
    add(0, 4); add(1, 5); add(2, 6); add(3, 7);
    drive();
    run_until(4, 20);
    chk("rst_ptr_restart", 64'(log_id[0]), 64'd0);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
